// File: rtl/a2d_spi_arb.sv
// Round-robin arbiter that shares one 16-bit SPI master between the A2D (0) and
// inertial (1) requesters. Ownership persists across transactions and is hold-limited.
module a2d_spi_arb #(
  parameter int unsigned HOLD_MAX = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [1:0]  wrt_in,
  input  logic [15:0] cmd0,
  input  logic [15:0] cmd1,
  output logic [1:0]  gnt,
  output logic [1:0]  done_out,
  output logic        spi_wrt,
  output logic [15:0] spi_cmd,
  input  logic        spi_done,
  input  logic        ss_n_in,
  output logic [1:0]  ss_n_out,
  output logic        proto_err,
  output logic        forced_rel
);

  localparam int unsigned CW = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

  typedef enum logic [1:0] {IDLE, GRANT, BUSY, REL} state_t;

  state_t        state, state_nxt;
  logic          owner, owner_nxt;
  logic          last_served, last_served_nxt;
  logic [1:0]    gnt_nxt;
  logic [CW-1:0] hold_cnt, hold_cnt_nxt;
  logic [1:0]    owner_oh;
  logic [1:0]    legal_wrt;

  assign owner_oh = owner ? 2'b10 : 2'b01;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_served <= 1'b1;
      gnt         <= '0;
      hold_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      last_served <= last_served_nxt;
      gnt         <= gnt_nxt;
      hold_cnt    <= hold_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    owner_nxt       = owner;
    last_served_nxt = last_served;
    gnt_nxt         = gnt;
    hold_cnt_nxt    = hold_cnt;
    forced_rel      = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          // The requester not served last wins whenever it is asking.
          owner_nxt    = req[~last_served] ? ~last_served : last_served;
          gnt_nxt      = owner_nxt ? 2'b10 : 2'b01;
          hold_cnt_nxt = '0;
          state_nxt    = GRANT;
        end
      end
      GRANT: begin
        if (wrt_in[owner]) begin
          hold_cnt_nxt = '0;
          state_nxt    = BUSY;
        end else if (!req[owner]) begin
          state_nxt = REL;
        end else if (req[~owner]) begin
          if (hold_cnt == HOLD_LAST) begin
            forced_rel = 1'b1;
            state_nxt  = REL;
          end else if (hold_cnt != '1) begin
            hold_cnt_nxt = hold_cnt + 1'b1;
          end
        end
      end
      BUSY: begin
        hold_cnt_nxt = '0;
        if (spi_done) state_nxt = GRANT;
      end
      REL: begin
        gnt_nxt         = '0;
        last_served_nxt = owner;
        state_nxt       = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign legal_wrt = (state == GRANT) ? owner_oh : 2'b00;
  assign spi_wrt   = (state == GRANT) && wrt_in[owner];
  assign spi_cmd   = (state == GRANT || state == BUSY) ? (owner ? cmd1 : cmd0) : '0;
  assign done_out  = (state == BUSY && spi_done) ? owner_oh : 2'b00;
  assign proto_err = (|(wrt_in & ~legal_wrt)) || (spi_done && state != BUSY);
  assign ss_n_out  = ~gnt | {2{ss_n_in}};

endmodule
